fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared processor package: datapath widths, default fetch geometry and the
// record stored in the fetch return buffer.
package fetch_unit_pkg;

  localparam int INSTR_W     = 16;
  localparam int PC_W        = 16;
  localparam int DEF_DEPTH   = 5;
  localparam int DEF_MEM_LAT = 2;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Return buffer for fetched instructions: circular queue of arbitrary depth
// with a combinational head, push/pop/clear and an occupancy count.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head_data,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  // Explicit wrap so that non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (clear) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= next_ptr(tail_reg);
      if (pop)  head_reg <= next_ptr(head_reg);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Storage carries no reset; stale entries are masked by a zero count.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail_reg] <= push_data;
  end

  assign head_data = mem[head_reg];
  assign count     = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: pc register, fixed-latency in-flight tracking
// and credit-based issue into a return buffer that feeds decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int        DEPTH    = DEF_DEPTH,
  parameter int        MEM_LAT  = DEF_MEM_LAT,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [PC_W-1:0]    out_pc
);

  localparam int FCNT_W = $clog2(DEPTH + 1);
  localparam int CRED_W = $clog2(DEPTH + MEM_LAT + 1);

  pc_t               pc_reg;
  logic              pipe_valid [MEM_LAT];
  pc_t               pipe_pc    [MEM_LAT];
  logic [FCNT_W-1:0] fifo_count;
  logic [CRED_W-1:0] inflight;
  logic [CRED_W-1:0] credit_used;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;
  logic              push;
  logic              pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + CRED_W'(pipe_valid[i]);
    end
  end

  // Every outstanding request already owns a buffer slot, so returns never drop.
  assign credit_used = CRED_W'(fifo_count) + inflight;
  assign imem_req    = !rst && !flush && (credit_used < CRED_W'(DEPTH));
  assign imem_addr   = pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pc_reg <= RESET_PC;
    else if (flush)    pc_reg <= redirect_pc;
    else if (imem_req) pc_reg <= pc_reg + PC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_pc[i]    <= '0;
      end
    end else begin
      pipe_valid[0] <= imem_req;
      pipe_pc[0]    <= pc_reg;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1] && !flush;
        pipe_pc[i]    <= pipe_pc[i-1];
      end
    end
  end

  assign push             = pipe_valid[MEM_LAT-1];
  assign push_entry.pc    = pipe_pc[MEM_LAT-1];
  assign push_entry.instr = imem_data;
  assign out_valid        = (fifo_count != '0);
  assign pop              = out_valid && !stall && !flush;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (fifo_count)
  );

  assign out_instruction = head_entry.instr;
  assign out_pc          = head_entry.pc;

endmodule
